// File: rtl/cart_bus_pkg.sv
// ---------------------------------------------------------------------------
// cart_bus_pkg
// Shared definitions for the cartridge bus initiator:
//   - cartState_e : sequencer states (idle, bus access, response, refresh)
//   - CYC_*       : bus access lengths in master clocks
//   - BANK_*/OFF_*: bank and offset boundaries used by the address decode
//   - isSystemBank: true for the banks that mirror the system area
//                   ($00-$3F and $80-$BF)
// ---------------------------------------------------------------------------
package cart_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2,
        ST_RFSH = 2'd3
    } cartState_e;

    localparam logic [3:0] CYC_FAST = 4'd6;
    localparam logic [3:0] CYC_NORM = 4'd8;
    localparam logic [3:0] CYC_SLOW = 4'd12;

    localparam logic [7:0]  BANK_LO_END   = 8'h3F;
    localparam logic [7:0]  BANK_HI_START = 8'h80;
    localparam logic [7:0]  BANK_HI_END   = 8'hBF;
    localparam logic [7:0]  BANK_WRAM_LO  = 8'h7E;
    localparam logic [7:0]  BANK_WRAM_HI  = 8'h7F;
    localparam logic [15:0] OFF_LORAM_END = 16'h1FFF;
    localparam logic [15:0] OFF_IO_START  = 16'h4000;
    localparam logic [15:0] OFF_IO_END    = 16'h41FF;

    function automatic logic isSystemBank(input logic [7:0] bank);
        return (bank <= BANK_LO_END) ||
               ((bank >= BANK_HI_START) && (bank <= BANK_HI_END));
    endfunction

endpackage

// File: rtl/cart_bus_decode.sv
// ---------------------------------------------------------------------------
// cart_bus_decode
// Purely combinational address decode for the cartridge bus.
// Ports:
//   ca_i       [23:0] cart address currently on the bus
//   fastrom_i         enables 6-clock accesses to ROM in banks $80-$FF
//   romSelEn_o        ROM select should be asserted for this address
//   ramSelEn_o        RAM select should be asserted for this address
//   cycleLen_o [3:0]  access length N in master clocks (6, 8 or 12)
// ---------------------------------------------------------------------------
module cart_bus_decode
    import cart_bus_pkg::*;
(
    input  logic [23:0] ca_i,
    input  logic        fastrom_i,
    output logic        romSelEn_o,
    output logic        ramSelEn_o,
    output logic [3:0]  cycleLen_o
);

    logic [7:0]  bank;
    logic [15:0] offset;
    logic        sysBank;
    logic        wramBank;
    logic        ioWindow;

    assign bank     = ca_i[23:16];
    assign offset   = ca_i[15:0];
    assign sysBank  = isSystemBank(bank);
    assign wramBank = (bank == BANK_WRAM_LO) || (bank == BANK_WRAM_HI);

    // The slow I/O window only exists in the system-area mirrors.
    assign ioWindow = sysBank && (offset >= OFF_IO_START) && (offset <= OFF_IO_END);

    // A22 selects ROM everywhere except the work-RAM banks, which also have A22 set.
    assign romSelEn_o = (ca_i[22] && !wramBank) || (ca_i[15] && sysBank);
    assign ramSelEn_o = wramBank || (sysBank && (offset <= OFF_LORAM_END));

    always_comb begin
        cycleLen_o = CYC_NORM;
        if (ioWindow) begin
            cycleLen_o = CYC_SLOW;
        end else if (romSelEn_o && ca_i[23] && fastrom_i) begin
            cycleLen_o = CYC_FAST;
        end
    end

endmodule

// File: rtl/cart_bus_initiator.sv
// ---------------------------------------------------------------------------
// cart_bus_initiator
// Turns single-beat read/write requests into timed cartridge bus cycles and
// inserts periodic refresh slots between them.
// Parameters:
//   REFRESH_PERIOD  master clocks between refresh slot starts
//   REFRESH_LEN     master clocks per refresh slot
// Ports:
//   MCLK, RST_N                    clock, asynchronous active-low reset
//   FASTROM                        enables 6-clock ROM accesses in banks $80-$FF
//   REQ_VALID/REQ_READY            request handshake
//   REQ_WE, REQ_ADDR, REQ_WDATA    write flag, cart address, write data
//   RSP_VALID, RSP_RDATA           one-clock completion pulse and its data
//   CA, DI, DO                     address bus, CPU-driven data, cart read data
//   CPURD_N, CPUWR_N               read / write strobes
//   ROMSEL_N, RAMSEL_N             ROM / RAM selects
//   SYSCLKF_CE, SYSCLKR_CE         access start / end pulses
//   REFRESH                        high for the duration of a refresh slot
// ---------------------------------------------------------------------------
module cart_bus_initiator
    import cart_bus_pkg::*;
#(
    parameter int REFRESH_PERIOD = 1364,
    parameter int REFRESH_LEN    = 40
) (
    input  logic        MCLK,
    input  logic        RST_N,
    input  logic        FASTROM,
    input  logic        REQ_VALID,
    output logic        REQ_READY,
    input  logic        REQ_WE,
    input  logic [23:0] REQ_ADDR,
    input  logic [7:0]  REQ_WDATA,
    output logic        RSP_VALID,
    output logic [7:0]  RSP_RDATA,
    output logic [23:0] CA,
    output logic [7:0]  DI,
    input  logic [7:0]  DO,
    output logic        CPURD_N,
    output logic        CPUWR_N,
    output logic        ROMSEL_N,
    output logic        RAMSEL_N,
    output logic        SYSCLKF_CE,
    output logic        SYSCLKR_CE,
    output logic        REFRESH
);

    // Phase counter must reach both the longest access and the refresh slot.
    localparam int PHASE_W = $clog2(REFRESH_LEN + 16);
    localparam int RC_W    = $clog2(REFRESH_PERIOD + 1);

    cartState_e         state_q, state_d;
    logic [PHASE_W-1:0] phaseCnt_q, phaseCnt_d;
    logic [RC_W-1:0]    refCnt_q, refCnt_d;
    logic               refPending_q, refPending_d;
    logic [23:0]        ca_q;
    logic [7:0]         di_q;
    logic [7:0]         wdata_q;
    logic [7:0]         rspRdata_q;
    logic               we_q;

    logic               romSelEn;
    logic               ramSelEn;
    logic [3:0]         cycleLen;
    logic               lastBus;
    logic               lastRfsh;
    logic               refWrap;
    logic               rfshEntry;
    logic               accept;

    cart_bus_decode uDecode (
        .ca_i       (ca_q),
        .fastrom_i  (FASTROM),
        .romSelEn_o (romSelEn),
        .ramSelEn_o (ramSelEn),
        .cycleLen_o (cycleLen)
    );

    assign lastBus   = (phaseCnt_q == PHASE_W'(cycleLen - 4'd1));
    assign lastRfsh  = (phaseCnt_q == PHASE_W'(REFRESH_LEN - 1));
    assign refWrap   = (refCnt_q == RC_W'(REFRESH_PERIOD - 1));
    assign rfshEntry = (state_q != ST_RFSH) && (state_d == ST_RFSH);

    // Gating with RST_N keeps READY low while reset is held, since the state
    // register already sits in IDLE during that time.
    assign REQ_READY = RST_N && (state_q == ST_IDLE) && !refPending_q;
    assign accept    = REQ_READY && REQ_VALID;

    always_ff @(posedge MCLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= ST_IDLE;
            phaseCnt_q <= '0;
        end else begin
            state_q    <= state_d;
            phaseCnt_q <= phaseCnt_d;
        end
    end

    // A pending refresh is only honoured at access boundaries (IDLE or the
    // clock after RESP) and beats a simultaneous request in IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (refPending_q) begin
                    state_d = ST_RFSH;
                end else if (REQ_VALID) begin
                    state_d = ST_BUS;
                end
            end
            ST_BUS:  if (lastBus) state_d = ST_RESP;
            ST_RESP: state_d = refPending_q ? ST_RFSH : ST_IDLE;
            ST_RFSH: if (lastRfsh) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        phaseCnt_d = phaseCnt_q + PHASE_W'(1);
        if ((state_d != state_q) || (state_q == ST_IDLE)) begin
            phaseCnt_d = '0;
        end
    end

    // Free-running refresh timer; a due refresh while one is still pending
    // simply re-sets the same flag, so the two merge. A wrap on the same clock
    // as slot entry still leaves a fresh request behind.
    always_comb begin
        refCnt_d     = refWrap ? '0 : refCnt_q + RC_W'(1);
        refPending_d = (refPending_q && !rfshEntry) || refWrap;
    end

    always_ff @(posedge MCLK or negedge RST_N) begin
        if (!RST_N) begin
            refCnt_q     <= '0;
            refPending_q <= 1'b0;
        end else begin
            refCnt_q     <= refCnt_d;
            refPending_q <= refPending_d;
        end
    end

    // Request latch and data path. DI doubles as the open-bus latch: reads
    // overwrite it with the sampled cart data, writes with the write data.
    always_ff @(posedge MCLK or negedge RST_N) begin
        if (!RST_N) begin
            ca_q       <= '0;
            di_q       <= 8'hFF;
            wdata_q    <= '0;
            rspRdata_q <= '0;
            we_q       <= 1'b0;
        end else begin
            if (accept) begin
                ca_q    <= REQ_ADDR;
                we_q    <= REQ_WE;
                wdata_q <= REQ_WDATA;
                if (REQ_WE) begin
                    di_q <= REQ_WDATA;
                end
            end
            if ((state_q == ST_BUS) && lastBus) begin
                if (we_q) begin
                    rspRdata_q <= wdata_q;
                end else begin
                    rspRdata_q <= DO;
                    di_q       <= DO;
                end
            end
        end
    end

    // Strobes are decoded from the registered state so that an asynchronous
    // reset releases the bus in the same cycle it is asserted.
    always_comb begin
        ROMSEL_N   = !((state_q == ST_BUS) && romSelEn);
        RAMSEL_N   = !((state_q == ST_BUS) && ramSelEn);
        SYSCLKF_CE = (state_q == ST_BUS) && (phaseCnt_q == '0);
        SYSCLKR_CE = (state_q == ST_BUS) && lastBus;
        CPURD_N    = !((state_q == ST_BUS) && !we_q && (phaseCnt_q >= PHASE_W'(2)));
        CPUWR_N    = !((state_q == ST_BUS) &&  we_q && (phaseCnt_q >= PHASE_W'(2)));
        REFRESH    = (state_q == ST_RFSH);
        RSP_VALID  = (state_q == ST_RESP);
        RSP_RDATA  = rspRdata_q;
        CA         = ca_q;
        DI         = di_q;
    end

endmodule

// File: tb/tb_cart_bus_initiator.sv
// ---------------------------------------------------------------------------
// tb_cart_bus_initiator
// Self-checking bench for cart_bus_initiator. A timeline model (access and
// refresh windows expressed as cycle ranges) predicts every output each
// cycle; directed transactions pin the model with literal latencies/values.
// ---------------------------------------------------------------------------
module tb_cart_bus_initiator;

    localparam int PERIOD = 1364;
    localparam int LEN    = 40;

    logic        MCLK = 1'b0;
    logic        RST_N;
    logic        FASTROM;
    logic        REQ_VALID;
    logic        REQ_READY;
    logic        REQ_WE;
    logic [23:0] REQ_ADDR;
    logic [7:0]  REQ_WDATA;
    logic        RSP_VALID;
    logic [7:0]  RSP_RDATA;
    logic [23:0] CA;
    logic [7:0]  DI;
    logic [7:0]  DO;
    logic        CPURD_N, CPUWR_N, ROMSEL_N, RAMSEL_N;
    logic        SYSCLKF_CE, SYSCLKR_CE, REFRESH;

    int checks = 0;
    int errors = 0;

    cart_bus_initiator #(
        .REFRESH_PERIOD (PERIOD),
        .REFRESH_LEN    (LEN)
    ) dut (
        .MCLK       (MCLK),
        .RST_N      (RST_N),
        .FASTROM    (FASTROM),
        .REQ_VALID  (REQ_VALID),
        .REQ_READY  (REQ_READY),
        .REQ_WE     (REQ_WE),
        .REQ_ADDR   (REQ_ADDR),
        .REQ_WDATA  (REQ_WDATA),
        .RSP_VALID  (RSP_VALID),
        .RSP_RDATA  (RSP_RDATA),
        .CA         (CA),
        .DI         (DI),
        .DO         (DO),
        .CPURD_N    (CPURD_N),
        .CPUWR_N    (CPUWR_N),
        .ROMSEL_N   (ROMSEL_N),
        .RAMSEL_N   (RAMSEL_N),
        .SYSCLKF_CE (SYSCLKF_CE),
        .SYSCLKR_CE (SYSCLKR_CE),
        .REFRESH    (REFRESH)
    );

    always #5 MCLK = ~MCLK;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Address map rules, written directly from the bank/offset description.
    function automatic bit mSysBank(input logic [23:0] a);
        return (a[23:16] < 8'h40) || ((a[23:16] >= 8'h80) && (a[23:16] < 8'hC0));
    endfunction

    function automatic bit mWram(input logic [23:0] a);
        return (a[23:16] == 8'h7E) || (a[23:16] == 8'h7F);
    endfunction

    function automatic bit mRomSel(input logic [23:0] a);
        return (a[22] && !mWram(a)) || (a[15] && mSysBank(a));
    endfunction

    function automatic bit mRamSel(input logic [23:0] a);
        return mWram(a) || (mSysBank(a) && (a[15:0] < 16'h2000));
    endfunction

    function automatic int mCycles(input logic [23:0] a, input logic fast);
        if (mSysBank(a) && (a[15:0] >= 16'h4000) && (a[15:0] < 16'h4200)) return 12;
        if (mRomSel(a) && a[23] && fast) return 6;
        return 8;
    endfunction

    // Timeline model: the access occupies cycles [busStart, busStart+busLen-1],
    // its response is cycle busStart+busLen, a refresh occupies
    // [rfStart, rfStart+LEN-1]. Cycle k is the one following edge k after reset.
    int          edgeCnt;
    int          busStart, busLen, rfStart;
    bit          busWe, pend;
    logic [7:0]  busWdata;
    logic [23:0] mCa;
    logic [7:0]  mDi, mRdata;

    always @(posedge MCLK or negedge RST_N) begin
        if (!RST_N) begin
            edgeCnt  = 0;
            busStart = -1000;
            busLen   = 8;
            rfStart  = -1000;
            busWe    = 1'b0;
            busWdata = 8'h00;
            pend     = 1'b0;
            mCa      = 24'h0;
            mDi      = 8'hFF;
            mRdata   = 8'h00;
        end else begin
            int  c;
            bit  wasIdle, wasLast, wasResp, wasRf, consumed;
            c        = edgeCnt;
            edgeCnt  = edgeCnt + 1;
            wasLast  = (c - busStart) == busLen - 1;
            wasResp  = (c - busStart) == busLen;
            wasRf    = (c >= rfStart) && (c < rfStart + LEN);
            wasIdle  = !((c >= busStart) && (c <= busStart + busLen)) && !wasRf;
            consumed = 1'b0;
            if (wasLast) begin
                if (busWe) begin
                    mRdata = busWdata;
                end else begin
                    mRdata = DO;
                    mDi    = DO;
                end
            end
            if (wasIdle && pend) begin
                rfStart  = edgeCnt;
                consumed = 1'b1;
            end else if (wasIdle && REQ_VALID) begin
                busStart = edgeCnt;
                busLen   = mCycles(REQ_ADDR, FASTROM);
                busWe    = REQ_WE;
                busWdata = REQ_WDATA;
                mCa      = REQ_ADDR;
                if (REQ_WE) mDi = REQ_WDATA;
            end
            if (wasResp && pend) begin
                rfStart  = edgeCnt;
                consumed = 1'b1;
            end
            pend = (pend && !consumed) || ((edgeCnt % PERIOD) == 0);
        end
    end

    // Compare process: every cycle, DUT outputs against the model or reset values.
    always @(negedge MCLK) begin
        if (!RST_N) begin
            checkOutput("rst_ready",   32'(REQ_READY), 32'd0);
            checkOutput("rst_strobes", {28'd0, CPURD_N, CPUWR_N, ROMSEL_N, RAMSEL_N}, 32'hF);
            checkOutput("rst_pulses",  {28'd0, SYSCLKF_CE, SYSCLKR_CE, REFRESH, RSP_VALID}, 32'h0);
            checkOutput("rst_ca",      32'(CA), 32'h0);
            checkOutput("rst_di",      32'(DI), 32'hFF);
            checkOutput("rst_rdata",   32'(RSP_RDATA), 32'h0);
        end else begin
            int cur, t;
            bit inBus, inResp, inRf, idle;
            cur    = edgeCnt;
            t      = cur - busStart;
            inBus  = (t >= 0) && (t < busLen);
            inResp = (t == busLen);
            inRf   = (cur >= rfStart) && (cur < rfStart + LEN);
            idle   = !inBus && !inResp && !inRf;
            checkOutput("req_ready",  32'(REQ_READY),  32'(idle && !pend));
            checkOutput("romsel_n",   32'(ROMSEL_N),   32'(!(inBus && mRomSel(mCa))));
            checkOutput("ramsel_n",   32'(RAMSEL_N),   32'(!(inBus && mRamSel(mCa))));
            checkOutput("cpurd_n",    32'(CPURD_N),    32'(!(inBus && !busWe && t >= 2)));
            checkOutput("cpuwr_n",    32'(CPUWR_N),    32'(!(inBus &&  busWe && t >= 2)));
            checkOutput("sysclkf_ce", 32'(SYSCLKF_CE), 32'(inBus && t == 0));
            checkOutput("sysclkr_ce", 32'(SYSCLKR_CE), 32'(inBus && t == busLen - 1));
            checkOutput("refresh",    32'(REFRESH),    32'(inRf));
            checkOutput("rsp_valid",  32'(RSP_VALID),  32'(inResp));
            checkOutput("rsp_rdata",  32'(RSP_RDATA),  32'(mRdata));
            checkOutput("ca",         32'(CA),         32'(mCa));
            checkOutput("di",         32'(DI),         32'(mDi));
        end
    end

    // Every completed refresh slot must be exactly LEN clocks long.
    int rfRun  = 0;
    int rfRuns = 0;
    always @(negedge MCLK) begin
        if (!RST_N) begin
            rfRun = 0;
        end else if (REFRESH) begin
            rfRun++;
        end else if (rfRun != 0) begin
            checkOutput("refresh_len", 32'(rfRun), 32'd40);
            rfRuns++;
            rfRun = 0;
        end
    end

    // Issue one request and follow it to its response, measuring bus activity.
    task automatic applyStimulus(input logic we, input logic [23:0] addr,
                                 input logic [7:0] wdata, input logic [7:0] doVal,
                                 output int lat, output int romLow, output int ramLow,
                                 output int rdLow, output int wrLow,
                                 output logic [7:0] rdata, output logic [7:0] diVal);
        bit got;
        lat = 0; romLow = 0; ramLow = 0; rdLow = 0; wrLow = 0;
        rdata = 8'h00; diVal = 8'h00;
        @(posedge MCLK); #2;
        DO        = doVal;
        REQ_WE    = we;
        REQ_ADDR  = addr;
        REQ_WDATA = wdata;
        REQ_VALID = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge MCLK);
            if (REQ_READY) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checkOutput("accept_timeout", 32'd0, 32'd1);
            REQ_VALID = 1'b0;
            return;
        end
        @(posedge MCLK); #2;
        REQ_VALID = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge MCLK);
            lat++;
            if (!ROMSEL_N) romLow++;
            if (!RAMSEL_N) ramLow++;
            if (!CPURD_N)  rdLow++;
            if (!CPUWR_N)  wrLow++;
            if (RSP_VALID) begin
                rdata = RSP_RDATA;
                diVal = DI;
                got = 1'b1;
                break;
            end
        end
        if (!got) checkOutput("rsp_timeout", 32'd0, 32'd1);
    endtask

    function automatic logic [23:0] randomAddr();
        logic [7:0]  bank;
        logic [15:0] off;
        case ($urandom_range(0, 4))
            0:       bank = 8'($urandom_range(0, 63));
            1:       bank = 8'(8'h80 + $urandom_range(0, 63));
            2:       bank = 8'(8'h7E + $urandom_range(0, 1));
            3:       bank = 8'(8'hC0 + $urandom_range(0, 63));
            default: bank = 8'($urandom());
        endcase
        case ($urandom_range(0, 3))
            0:       off = 16'($urandom_range(0, 16'h1FFF));
            1:       off = 16'(16'h4000 + $urandom_range(0, 16'h1FF));
            2:       off = 16'(16'h8000 + $urandom_range(0, 16'h7FFF));
            default: off = 16'($urandom());
        endcase
        return {bank, off};
    endfunction

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int         lat, romLow, ramLow, rdLow, wrLow, rspCnt;
        logic [7:0] rdata, diVal;
        bit         got;

        RST_N     = 1'b0;
        FASTROM   = 1'b0;
        REQ_VALID = 1'b0;
        REQ_WE    = 1'b0;
        REQ_ADDR  = 24'h0;
        REQ_WDATA = 8'h00;
        DO        = 8'h00;
        repeat (3) @(posedge MCLK);
        #2 RST_N = 1'b1;
        #1 checkOutput("ready_after_release", 32'(REQ_READY), 32'd1);

        $display("[TB] directed: ROM read at $00:8000");
        applyStimulus(1'b0, 24'h008000, 8'h00, 8'hA5, lat, romLow, ramLow, rdLow, wrLow, rdata, diVal);
        checkOutput("rd_lat",     32'(lat),    32'd9);
        checkOutput("rd_romlow",  32'(romLow), 32'd8);
        checkOutput("rd_ramlow",  32'(ramLow), 32'd0);
        checkOutput("rd_cpurd",   32'(rdLow),  32'd6);
        checkOutput("rd_cpuwr",   32'(wrLow),  32'd0);
        checkOutput("rd_rdata",   32'(rdata),  32'hA5);
        checkOutput("rd_openbus", 32'(diVal),  32'hA5);

        $display("[TB] directed: FastROM at $80:8000");
        FASTROM = 1'b1;
        applyStimulus(1'b0, 24'h808000, 8'h00, 8'h5A, lat, romLow, ramLow, rdLow, wrLow, rdata, diVal);
        checkOutput("fast_lat",    32'(lat),    32'd7);
        checkOutput("fast_romlow", 32'(romLow), 32'd6);
        checkOutput("fast_rdata",  32'(rdata),  32'h5A);
        FASTROM = 1'b0;
        applyStimulus(1'b0, 24'h808000, 8'h00, 8'h11, lat, romLow, ramLow, rdLow, wrLow, rdata, diVal);
        checkOutput("slowrom_lat", 32'(lat), 32'd9);

        $display("[TB] directed: writes to WRAM and I/O window");
        applyStimulus(1'b1, 24'h7E0010, 8'h3C, 8'hEE, lat, romLow, ramLow, rdLow, wrLow, rdata, diVal);
        checkOutput("wr_ramlow", 32'(ramLow), 32'd8);
        checkOutput("wr_romlow", 32'(romLow), 32'd0);
        checkOutput("wr_cpuwr",  32'(wrLow),  32'd6);
        checkOutput("wr_cpurd",  32'(rdLow),  32'd0);
        checkOutput("wr_di",     32'(diVal),  32'h3C);
        checkOutput("wr_rdata",  32'(rdata),  32'h3C);
        applyStimulus(1'b1, 24'h004016, 8'h77, 8'hEE, lat, romLow, ramLow, rdLow, wrLow, rdata, diVal);
        checkOutput("io_lat", 32'(lat), 32'd13);

        $display("[TB] directed: reset in the middle of a read");
        @(posedge MCLK); #2;
        REQ_WE    = 1'b0;
        REQ_ADDR  = 24'h008000;
        REQ_VALID = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge MCLK);
            if (REQ_READY) begin
                got = 1'b1;
                break;
            end
        end
        checkOutput("rst_test_accept", 32'(got), 32'd1);
        @(posedge MCLK); #2;
        REQ_VALID = 1'b0;
        repeat (4) @(posedge MCLK);
        #2 checkOutput("t4_cpurd_low", 32'(CPURD_N), 32'd0);
        RST_N = 1'b0;
        #1;
        checkOutput("t4_rst_cpurd",  32'(CPURD_N),  32'd1);
        checkOutput("t4_rst_romsel", 32'(ROMSEL_N), 32'd1);
        checkOutput("t4_rst_ready",  32'(REQ_READY), 32'd0);
        repeat (3) @(posedge MCLK);
        #2 RST_N = 1'b1;
        #1 checkOutput("t4_ready_after", 32'(REQ_READY), 32'd1);
        rspCnt = 0;
        repeat (15) begin
            @(negedge MCLK);
            if (RSP_VALID) rspCnt++;
        end
        checkOutput("t4_no_rsp", 32'(rspCnt), 32'd0);

        $display("[TB] random traffic across several refresh periods");
        for (int n = 0; n < 320; n++) begin
            if ($urandom_range(0, 3) == 0) FASTROM = ~FASTROM;
            applyStimulus(1'($urandom_range(0, 1)), randomAddr(), 8'($urandom()), 8'($urandom()),
                          lat, romLow, ramLow, rdLow, wrLow, rdata, diVal);
            repeat ($urandom_range(0, 2)) @(posedge MCLK);
        end
        repeat (60) @(negedge MCLK);
        checkOutput("refresh_slots_seen", 32'(rfRuns >= 2), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cart_bus_initiator.md
CART_BUS_INITIATOR -- requirements
Module: cart_bus_initiator

Interface
REQ-001 Parameter REFRESH_PERIOD, default 1364; master clocks between refresh slot starts.
REQ-002 Parameter REFRESH_LEN, default 40; master clocks per refresh slot.
REQ-003 MCLK  in  1  single clock; every cycle is one master clock.
REQ-004 RST_N  in  1  asynchronous, active-low reset.
REQ-005 FASTROM  in  1  enables 6-clock ROM cycles in banks $80-$FF.
REQ-006 REQ_VALID / REQ_READY  in / out  1 / 1  transaction request handshake; transfer when both are high on an MCLK edge.
REQ-007 REQ_WE, REQ_ADDR, REQ_WDATA  in  1, 24, 8  write flag, cart address, write data.
REQ-008 RSP_VALID, RSP_RDATA  out  1, 8  one-cycle completion pulse and read data.
REQ-009 CA, DI  out  24, 8  cart address bus and CPU-driven data bus.
REQ-010 DO  in  8  cart read data.
REQ-011 CPURD_N, CPUWR_N, ROMSEL_N, RAMSEL_N  out  1 each  bus strobes and selects.
REQ-012 SYSCLKF_CE, SYSCLKR_CE, REFRESH  out  1 each  cycle-start pulse, cycle-end pulse, and refresh indicator.

Function
REQ-013 States: IDLE, BUS (N-clock access), RESP (1 clock), RFSH (REFRESH_LEN clocks).
REQ-014 REQ_READY is high only in IDLE with no pending refresh; an accepted request latches address, WE and data and enters BUS at t=0.
REQ-015 N is 12 for banks $00-$3F/$80-$BF at $4000-$41FF.
REQ-016 N is 6 when ROMSEL is selected and CA[23]=1 and FASTROM=1.
REQ-017 N is 8 in all other cases.
REQ-018 ROMSEL_N is low during BUS when CA[22]=1 and the bank is not $7E/$7F, or when CA[15]=1 in banks $00-$3F/$80-$BF.
REQ-019 RAMSEL_N is low during BUS for banks $7E-$7F, or for $0000-$1FFF in banks $00-$3F/$80-$BF.
REQ-020 ROMSEL_N and RAMSEL_N are high outside BUS.
REQ-021 CA holds the latched address from t=0 through t=N-1; CA retains its last value outside BUS.
REQ-022 SYSCLKF_CE pulses high for exactly one clock at t=0 of each BUS.
REQ-023 SYSCLKR_CE pulses high for exactly one clock at t=N-1.
REQ-024 CPURD_N (read) or CPUWR_N (write) is low for t=2..N-1 inclusive; the two strobes are never low together.
REQ-025 On a write, DI carries REQ_WDATA from t=0.
REQ-026 On a read, DO is sampled at t=N-1, and DI then holds the sampled value (open-bus model) until the next write.
REQ-027 RESP asserts RSP_VALID for one clock.
REQ-028 RSP_RDATA holds the sampled read data, or REQ_WDATA for a write; RSP_RDATA is stable until the next RESP.
REQ-029 Latency from the accepting edge to RSP_VALID is N+1 clocks; the next acceptance is possible one clock after RESP.
REQ-030 A free-running refresh counter wraps at REFRESH_PERIOD-1 and sets refresh_pending.
REQ-031 A pending refresh never interrupts BUS; it starts from IDLE or immediately after RESP.
REQ-032 If a refresh is pending and REQ_VALID is high in IDLE on the same clock, the refresh wins and the request waits.
REQ-033 In RFSH, REFRESH is high for REFRESH_LEN clocks with all selects and strobes inactive; refresh_pending clears on entry.
REQ-034 A second refresh that becomes due while one is pending is merged into it, not queued.

Reset
REQ-035 Asserting RST_N low forces IDLE immediately, including mid-BUS or mid-RFSH.
REQ-036 Reset values: CA=0, DI=$FF, CPURD_N/CPUWR_N/ROMSEL_N/RAMSEL_N=1, SYSCLKF_CE/SYSCLKR_CE/REFRESH/RSP_VALID=0, RSP_RDATA=0.
REQ-037 Reset clears the refresh counter and refresh_pending; REQ_READY is 0 during reset and 1 on the first clock after release.

Structure
REQ-038 The shared package holds the state enum, the cycle-length constants (6/8/12), and the bank/offset decode boundary constants.
REQ-039 One combinational sub-module, cart_bus_decode, maps CA and FASTROM to ROMSEL_N/RAMSEL_N enables and N.
REQ-040 All sequencing lives in cart_bus_initiator.

Verification
REQ-041 Read $00:8000 with FASTROM=0 and DO=$A5 -> ROMSEL_N low for 8 clocks, CPURD_N low t=2..7, RSP_VALID 9 clocks after acceptance with RSP_RDATA=$A5, DI=$A5.
REQ-042 Read $80:8000 with FASTROM=1 -> N=6 and RSP_VALID 7 clocks after acceptance; the same read with FASTROM=0 -> N=8.
REQ-043 Write $7E:0010=$3C -> RAMSEL_N low, ROMSEL_N high, CPUWR_N low t=2..7, DI=$3C; a write to $00:4016 -> N=12.
REQ-044 Refresh comes due mid-BUS while the next request waits -> the BUS completes, then RFSH with REFRESH high for 40 clocks, then the request is accepted.
REQ-045 RST_N asserted at t=4 of a read -> all strobes and selects high in the same cycle, no RSP_VALID, REQ_READY=1 on the first clock after release.
